song_sequencer: RTL

SONG_SEQUENCER -- requirements
Module: song_sequencer

---
 rtl/song_sequencer_pkg.sv | 39 +++
 rtl/song_sequencer_beat_timer.sv | 46 ++++
 rtl/song_sequencer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/song_sequencer_pkg.sv
// Shared definitions for the song sequencer: FSM states, ROM entry codes and
// the note-length decoder.
package song_sequencer_pkg;

   localparam int unsigned DUR_WIDTH = 26;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StFetch = 3'd1,
      StWait  = 3'd2,
      StPlay  = 3'd3,
      StDone  = 3'd4
   } seq_state_e;

   // Length code in rom_data[7:6]: number of beats the entry lasts
   localparam logic [1:0] LEN_1_BEAT  = 2'd0;
   localparam logic [1:0] LEN_2_BEATS = 2'd1;
   localparam logic [1:0] LEN_4_BEATS = 2'd2;
   localparam logic [1:0] LEN_8_BEATS = 2'd3;

   localparam logic [7:0] END_MARKER = 8'hFF;
   localparam logic [5:0] REST       = 6'd0;

   // Note duration in clock cycles; 8 * 2^22 still fits in DUR_WIDTH bits
   function automatic logic [DUR_WIDTH-1:0] note_cycles(input logic [1:0]           len_code,
                                                         input logic [DUR_WIDTH-1:0] beat);
      logic [DUR_WIDTH-1:0] w_dur;
      w_dur = beat;
      case (len_code)
         LEN_1_BEAT:  w_dur = beat;
         LEN_2_BEATS: w_dur = beat << 1;
         LEN_4_BEATS: w_dur = beat << 2;
         LEN_8_BEATS: w_dur = beat << 3;
         default:     w_dur = beat;
      endcase
      return w_dur;
   endfunction

endpackage

// File: rtl/song_sequencer_beat_timer.sv
// Loadable note-duration down-counter plus the articulation-gap counter.
// Both flags look one edge ahead so the FSM can update its registered
// outputs on the same edge that the condition takes effect.
module song_sequencer_beat_timer
   import song_sequencer_pkg::*;
#(
   parameter int unsigned GAP_CYCLES = 262144
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_clear,
   input  logic                 i_load,
   input  logic                 i_run,
   input  logic [DUR_WIDTH-1:0] i_load_val,
   output logic                 o_expiring,
   output logic                 o_gap_elapsing
);

   localparam logic [DUR_WIDTH-1:0] GAP_VAL = DUR_WIDTH'(GAP_CYCLES);

   logic [DUR_WIDTH-1:0] r_count;
   logic [DUR_WIDTH-1:0] r_gap;

   // Clear beats load, load beats run; both counters stop at zero
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_count <= '0;
         r_gap   <= '0;
      end else if (i_clear) begin
         r_count <= '0;
         r_gap   <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
         r_gap   <= GAP_VAL;
      end else if (i_run) begin
         if (r_count != '0) r_count <= r_count - 1'b1;
         if (r_gap != '0)   r_gap   <= r_gap - 1'b1;
      end
   end

   // Last cycle of the note: the count hits zero on the coming edge
   assign o_expiring     = (r_count == DUR_WIDTH'(1));
   // Gap is over once the coming edge has passed
   assign o_gap_elapsing = (r_gap <= DUR_WIDTH'(1));

endmodule

// File: rtl/song_sequencer.sv
// Song sequencer: walks an external synchronous song ROM, producing a note
// index and an articulated gate for the tone generator.
module song_sequencer
   import song_sequencer_pkg::*;
#(
   parameter int unsigned BEAT_CYCLES = 4194304,
   parameter int unsigned GAP_CYCLES  = 262144
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_play,
   input  logic       i_loop,
   input  logic [7:0] i_rom_data,
   output logic [7:0] o_rom_addr,
   output logic [7:0] o_fullnote,
   output logic       o_note_gate,
   output logic       o_busy,
   output logic       o_song_end
);

   localparam logic [DUR_WIDTH-1:0] BEAT_VAL = DUR_WIDTH'(BEAT_CYCLES);

   seq_state_e r_state;
   logic [7:0] r_rom_addr;
   logic [7:0] r_fullnote;
   logic       r_note_gate;
   logic       r_busy;
   logic       r_song_end;

   logic                 w_is_marker;
   logic                 w_timer_load;
   logic                 w_timer_run;
   logic                 w_expiring;
   logic                 w_gap_elapsing;
   logic [DUR_WIDTH-1:0] w_load_val;

   assign w_is_marker  = (i_rom_data == END_MARKER);
   assign w_timer_load = (r_state == StWait) && !w_is_marker;
   assign w_timer_run  = (r_state == StPlay);
   assign w_load_val   = note_cycles(i_rom_data[7:6], BEAT_VAL);

   song_sequencer_beat_timer #(
      .GAP_CYCLES (GAP_CYCLES)
   ) u_beat_timer (
      .i_clk          (i_clk),
      .i_reset        (i_reset),
      .i_clear        (!i_play),
      .i_load         (w_timer_load),
      .i_run          (w_timer_run),
      .i_load_val     (w_load_val),
      .o_expiring     (w_expiring),
      .o_gap_elapsing (w_gap_elapsing)
   );

   // Sequencer FSM; play low overrides every other condition and rewinds
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state     <= StIdle;
         r_rom_addr  <= '0;
         r_fullnote  <= '0;
         r_note_gate <= 1'b0;
         r_busy      <= 1'b0;
         r_song_end  <= 1'b0;
      end else if (!i_play) begin
         r_state     <= StIdle;
         r_rom_addr  <= '0;
         r_fullnote  <= '0;
         r_note_gate <= 1'b0;
         r_busy      <= 1'b0;
         r_song_end  <= 1'b0;
      end else begin
         r_song_end <= 1'b0;
         unique case (r_state)
            StIdle: begin
               r_state    <= StFetch;
               r_rom_addr <= '0;
               r_busy     <= 1'b1;
            end
            StFetch: begin
               r_state <= StWait;
            end
            StWait: begin
               r_note_gate <= 1'b0;
               if (w_is_marker) begin
                  r_song_end <= 1'b1;
                  if (i_loop) begin
                     // Previous note stays on fullnote through the refetch
                     r_state    <= StFetch;
                     r_rom_addr <= '0;
                  end else begin
                     r_state    <= StDone;
                     r_fullnote <= '0;
                     r_busy     <= 1'b0;
                  end
               end else begin
                  r_state    <= StPlay;
                  r_fullnote <= {2'b00, i_rom_data[5:0]};
               end
            end
            StPlay: begin
               if (w_expiring) begin
                  r_state     <= StFetch;
                  r_rom_addr  <= r_rom_addr + 8'd1;
                  r_note_gate <= 1'b0;
               end else if (w_gap_elapsing && (r_fullnote[5:0] != REST)) begin
                  r_note_gate <= 1'b1;
               end
            end
            StDone: begin
               r_fullnote  <= '0;
               r_note_gate <= 1'b0;
               r_busy      <= 1'b0;
            end
            default: begin
               r_state     <= StIdle;
               r_rom_addr  <= '0;
               r_fullnote  <= '0;
               r_note_gate <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign o_rom_addr  = r_rom_addr;
   assign o_fullnote  = r_fullnote;
   assign o_note_gate = r_note_gate;
   assign o_busy      = r_busy;
   assign o_song_end  = r_song_end;

endmodule
